// File: rtl/regfile_access_arbiter_if.sv
// Requester and register-file signals for the two-port register file access arbiter.
// slave is the arbiter view; master is the requester/register-file view.
interface regfile_access_arbiter_if #(
    parameter int XLEN = 32
);
    logic            a_req_valid;
    logic            a_req_ready;
    logic            a_req_write;
    logic [4:0]      a_req_addr;
    logic [XLEN-1:0] a_req_wdata;
    logic            a_rsp_valid;
    logic [XLEN-1:0] a_rsp_rdata;

    logic            b_req_valid;
    logic            b_req_ready;
    logic            b_req_write;
    logic [4:0]      b_req_addr;
    logic [XLEN-1:0] b_req_wdata;
    logic            b_rsp_valid;
    logic [XLEN-1:0] b_rsp_rdata;

    logic [4:0]      rf_rs1;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_write_data;
    logic            rf_write_enable;
    logic [XLEN-1:0] rf_rs1_data;

    modport slave (
        input  a_req_valid, a_req_write, a_req_addr, a_req_wdata,
        output a_req_ready, a_rsp_valid, a_rsp_rdata,
        input  b_req_valid, b_req_write, b_req_addr, b_req_wdata,
        output b_req_ready, b_rsp_valid, b_rsp_rdata,
        output rf_rs1, rf_rd, rf_write_data, rf_write_enable,
        input  rf_rs1_data
    );

    modport master (
        output a_req_valid, a_req_write, a_req_addr, a_req_wdata,
        input  a_req_ready, a_rsp_valid, a_rsp_rdata,
        output b_req_valid, b_req_write, b_req_addr, b_req_wdata,
        input  b_req_ready, b_rsp_valid, b_rsp_rdata,
        input  rf_rs1, rf_rd, rf_write_data, rf_write_enable,
        output rf_rs1_data
    );
endinterface

// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter sharing a register file's write port and rs1 read port
// between two valid/ready requesters, with an optional clear sweep after reset.
//   state    | meaning
//   CLEAR    | zeroing x1..NUM_REGS-1 one per cycle (one pass-through cycle if clearing disabled)
//   IDLE     | granting at most one request per cycle
//   RD_WAIT  | returning synchronous read data to the owner of the last read grant
module regfile_access_arbiter #(
    parameter int NUM_REGS       = 32,
    parameter int XLEN           = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                    clk,
    input  logic                    resetn,
    regfile_access_arbiter_if.slave bus,
    output logic                    init_done
);
    typedef enum logic [1:0] {
        ST_CLEAR   = 2'd0,
        ST_IDLE    = 2'd1,
        ST_RD_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_t          state, state_nxt;
    logic [4:0]      clr_idx, clr_idx_nxt;
    grant_t          last_grant, last_grant_nxt;
    grant_t          rd_owner, rd_owner_nxt;
    logic            rd_zero, rd_zero_nxt;
    logic            init_done_nxt;

    logic            a_ready;
    logic            b_ready;
    logic            win_write;
    logic [4:0]      win_addr;
    logic [XLEN-1:0] win_wdata;
    logic            win_in_range;

    logic [4:0]      rs1;
    logic [4:0]      rd;
    logic [XLEN-1:0] wdata;
    logic            we;
    logic            a_rsp_valid;
    logic            b_rsp_valid;
    logic [XLEN-1:0] a_rsp_rdata;
    logic [XLEN-1:0] b_rsp_rdata;
    logic [XLEN-1:0] rsp_data;

    // Round-robin: on a tie the requester that did not win last gets the slot.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (state == ST_IDLE) begin
            a_ready = bus.a_req_valid && (!bus.b_req_valid || (last_grant == GRANT_B));
            b_ready = bus.b_req_valid && !a_ready;
        end
    end

    always_comb begin
        win_write = bus.a_req_write;
        win_addr  = bus.a_req_addr;
        win_wdata = bus.a_req_wdata;
        if (b_ready) begin
            win_write = bus.b_req_write;
            win_addr  = bus.b_req_addr;
            win_wdata = bus.b_req_wdata;
        end
        win_in_range = ({27'd0, win_addr} < 32'(NUM_REGS));
    end

    // x0 and out-of-range reads return zero regardless of what the file drives.
    assign rsp_data = rd_zero ? '0 : bus.rf_rs1_data;

    always_comb begin
        state_nxt      = state;
        clr_idx_nxt    = clr_idx;
        last_grant_nxt = last_grant;
        rd_owner_nxt   = rd_owner;
        rd_zero_nxt    = rd_zero;
        init_done_nxt  = init_done;
        rs1            = '0;
        rd             = '0;
        wdata          = '0;
        we             = 1'b0;
        a_rsp_valid    = 1'b0;
        b_rsp_valid    = 1'b0;
        a_rsp_rdata    = '0;
        b_rsp_rdata    = '0;

        unique case (state)
            ST_CLEAR: begin
                if (CLEAR_ON_RESET) begin
                    // Gated by resetn so the register file sees no write while held in reset.
                    if (resetn) begin
                        we = 1'b1;
                        rd = clr_idx;
                    end
                    clr_idx_nxt = clr_idx + 5'd1;
                    if (clr_idx == LAST_IDX) begin
                        state_nxt     = ST_IDLE;
                        init_done_nxt = 1'b1;
                        clr_idx_nxt   = 5'd1;
                    end
                end else begin
                    state_nxt     = ST_IDLE;
                    init_done_nxt = 1'b1;
                end
            end

            ST_IDLE: begin
                if (a_ready || b_ready) begin
                    last_grant_nxt = b_ready ? GRANT_B : GRANT_A;
                    if (win_write) begin
                        if (win_in_range) begin
                            we    = 1'b1;
                            rd    = win_addr;
                            wdata = win_wdata;
                        end
                    end else begin
                        rs1          = win_addr;
                        state_nxt    = ST_RD_WAIT;
                        rd_owner_nxt = b_ready ? GRANT_B : GRANT_A;
                        rd_zero_nxt  = (win_addr == 5'd0) || !win_in_range;
                    end
                end
            end

            ST_RD_WAIT: begin
                state_nxt = ST_IDLE;
                if (rd_owner == GRANT_A) begin
                    a_rsp_valid = 1'b1;
                    a_rsp_rdata = rsp_data;
                end else begin
                    b_rsp_valid = 1'b1;
                    b_rsp_rdata = rsp_data;
                end
            end

            default: begin
                state_nxt = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_CLEAR;
            clr_idx    <= 5'd1;
            last_grant <= GRANT_B;
            rd_owner   <= GRANT_A;
            rd_zero    <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            clr_idx    <= clr_idx_nxt;
            last_grant <= last_grant_nxt;
            rd_owner   <= rd_owner_nxt;
            rd_zero    <= rd_zero_nxt;
            init_done  <= init_done_nxt;
        end
    end

    assign bus.a_req_ready     = a_ready;
    assign bus.b_req_ready     = b_ready;
    assign bus.a_rsp_valid     = a_rsp_valid;
    assign bus.b_rsp_valid     = b_rsp_valid;
    assign bus.a_rsp_rdata     = a_rsp_rdata;
    assign bus.b_rsp_rdata     = b_rsp_rdata;
    assign bus.rf_rs1          = rs1;
    assign bus.rf_rd           = rd;
    assign bus.rf_write_data   = wdata;
    assign bus.rf_write_enable = we;
endmodule
